// File: rtl/multicycle_stage_sequencer_if.sv
// Handshake/bus bundle for the multi-cycle stage sequencer: decode/memory inputs,
// PC and one-hot stage enables out, plus the optional perf counters.
interface multicycle_stage_sequencer_if #(
    parameter int WORD = 64
);
    logic            run;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_ack;
    logic            pc_src;
    logic [WORD-1:0] branch_target;
    logic [WORD-1:0] pc;
    logic            fetch_en;
    logic            reg_read_en;
    logic            exec_en;
    logic            mem_req;
    logic            reg_write_en;
    logic            busy;
    logic [2:0]      stage;
    logic [31:0]     cycle_count;
    logic [31:0]     instr_count;

    modport master (
        output run, mem_read, mem_write, reg_write, mem_ack, pc_src, branch_target,
        input  pc, fetch_en, reg_read_en, exec_en, mem_req, reg_write_en, busy, stage,
               cycle_count, instr_count
    );

    modport slave (
        input  run, mem_read, mem_write, reg_write, mem_ack, pc_src, branch_target,
        output pc, fetch_en, reg_read_en, exec_en, mem_req, reg_write_en, busy, stage,
               cycle_count, instr_count
    );
endinterface

// File: rtl/multicycle_stage_sequencer.sv
// One-clock multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer owning the PC.
// Optional perf counters enabled by defining SEQ_PERF_COUNTERS_EN.
module multicycle_stage_sequencer #(
    parameter int              WORD       = 64,
    parameter logic [WORD-1:0] RESET_PC   = '0,
    parameter int              FETCH_CYC  = 2,
    parameter int              DECODE_CYC = 1,
    parameter int              EXEC_CYC   = 1,
    parameter int              WB_CYC     = 1,
    parameter int              CNT_W      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_stage_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FETCH_CYC - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DECODE_CYC - 1);
    localparam logic [CNT_W-1:0] E_LAST = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WB_CYC - 1);

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last, latch, pc_upd, rw_nxt;
    logic [WORD-1:0]  pc_q, tgt_q;
    logic             rw_q, ps_q;
    logic             fetch_en_q, reg_read_en_q, exec_en_q, mem_req_q, reg_write_en_q, busy_q;

    always_comb begin
        last = 1'b0;
        case (state)
            FETCH:     last = (cnt == F_LAST);
            DECODE:    last = (cnt == D_LAST);
            EXECUTE:   last = (cnt == E_LAST);
            WRITEBACK: last = (cnt == W_LAST);
            default:   last = 1'b0;
        endcase
    end

    always_comb begin
        nxt   = state;
        latch = 1'b0;
        case (state)
            IDLE:      if (bus.run) nxt = FETCH;
            FETCH:     if (last) nxt = DECODE;
            DECODE:    if (last) nxt = EXECUTE;
            EXECUTE:   if (last) begin
                           latch = 1'b1;
                           nxt   = (bus.mem_read | bus.mem_write) ? MEMORY : WRITEBACK;
                       end
            MEMORY:    if (bus.mem_ack) nxt = WRITEBACK;
            WRITEBACK: if (last) nxt = bus.run ? FETCH : IDLE;
            default:   nxt = IDLE;
        endcase
        // MEMORY stalls are unbounded, so the dwell counter is parked there instead of counting.
        cnt_nxt = (nxt != state || nxt == MEMORY || nxt == IDLE) ? '0 : cnt + CNT_W'(1);
        rw_nxt  = latch ? bus.reg_write : rw_q;
        pc_upd  = (state == WRITEBACK) && last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            pc_q           <= RESET_PC;
            tgt_q          <= '0;
            rw_q           <= 1'b0;
            ps_q           <= 1'b0;
            fetch_en_q     <= 1'b0;
            reg_read_en_q  <= 1'b0;
            exec_en_q      <= 1'b0;
            mem_req_q      <= 1'b0;
            reg_write_en_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                rw_q  <= bus.reg_write;
                ps_q  <= bus.pc_src;
                tgt_q <= bus.branch_target;
            end
            if (pc_upd) pc_q <= ps_q ? tgt_q : pc_q + WORD'(4);
            // Enables are decoded from the next state so they are live on the entry cycle.
            fetch_en_q     <= (nxt == FETCH);
            reg_read_en_q  <= (nxt == DECODE) && (cnt_nxt == D_LAST);
            exec_en_q      <= (nxt == EXECUTE);
            mem_req_q      <= (nxt == MEMORY);
            reg_write_en_q <= (nxt == WRITEBACK) && (cnt_nxt == W_LAST) && rw_nxt;
            busy_q         <= (nxt != IDLE);
        end
    end

    assign bus.pc           = pc_q;
    assign bus.stage        = state;
    assign bus.fetch_en     = fetch_en_q;
    assign bus.reg_read_en  = reg_read_en_q;
    assign bus.exec_en      = exec_en_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.reg_write_en = reg_write_en_q;
    assign bus.busy         = busy_q;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [31:0] cyc_q, ins_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (state != IDLE) cyc_q <= cyc_q + 32'd1;
            if (pc_upd)        ins_q <= ins_q + 32'd1;
        end
    end

    assign bus.cycle_count = cyc_q;
    assign bus.instr_count = ins_q;
`else
    assign bus.cycle_count = 32'd0;
    assign bus.instr_count = 32'd0;
`endif
endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// Randomized bench: each instruction is expanded into its expected per-cycle stage list and
// the sequencer outputs are compared against that list every cycle.
module tb_multicycle_stage_sequencer;
    localparam int WORD = 64;
    localparam int FC = 2, DC = 1, EC = 1, WC = 1;
    localparam logic [WORD-1:0] RPC = '0;
`ifdef SEQ_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_stage_sequencer_if #(.WORD(WORD)) bus ();

    multicycle_stage_sequencer #(
        .WORD(WORD), .RESET_PC(RPC), .FETCH_CYC(FC), .DECODE_CYC(DC),
        .EXEC_CYC(EC), .WB_CYC(WC), .CNT_W(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_vec = 0, n_err = 0;
    logic [63:0] m_pc  = RPC;
    logic [31:0] m_cyc = 0, m_ins = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic noise();
        bus.mem_read      = 1'($urandom);
        bus.mem_write     = 1'($urandom);
        bus.reg_write     = 1'($urandom);
        bus.pc_src        = 1'($urandom);
        bus.mem_ack       = 1'($urandom);
        bus.run           = 1'($urandom);
        bus.branch_target = {$urandom, $urandom};
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stage"}, 64'(bus.stage), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_en"}, 64'({bus.fetch_en, bus.reg_read_en, bus.exec_en, bus.mem_req,
                               bus.reg_write_en}), 64'd0);
        chk({tag, "_pc"}, bus.pc, m_pc);
        chk({tag, "_cyc"}, 64'(bus.cycle_count), PERF ? 64'(m_cyc) : 64'd0);
        chk({tag, "_ins"}, 64'(bus.instr_count), PERF ? 64'(m_ins) : 64'd0);
    endtask

    // Sit in IDLE for extra+1 cycles, then request the next instruction.
    task automatic go_idle(input int extra);
        for (int i = 0; i <= extra; i++) begin
            @(negedge clk);
            chk_quiet("idle");
            noise();
            bus.run = (i == extra);
        end
    endtask

    // Assumes the DUT enters FETCH on the coming posedge.
    task automatic do_instr(input bit rd, input bit wr, input bit rw, input bit ps,
                            input logic [63:0] tgt, input int ack_dly, input bit cont);
        int stg[$];
        int mi = 0;
        for (int i = 0; i < FC; i++) stg.push_back(1);
        for (int i = 0; i < DC; i++) stg.push_back(2);
        for (int i = 0; i < EC; i++) stg.push_back(3);
        if (rd | wr) for (int i = 0; i < ack_dly; i++) stg.push_back(4);
        for (int i = 0; i < WC; i++) stg.push_back(5);
        for (int k = 0; k < stg.size(); k++) begin
            int s;
            bit last_d, last_e, last_w;
            s      = stg[k];
            last_d = (k == FC + DC - 1);
            last_e = (k == FC + DC + EC - 1);
            last_w = (k == stg.size() - 1);
            @(negedge clk);
            chk("stage", 64'(bus.stage), 64'(s));
            chk("fetch_en", 64'(bus.fetch_en), 64'(s == 1));
            chk("reg_read_en", 64'(bus.reg_read_en), 64'(last_d));
            chk("exec_en", 64'(bus.exec_en), 64'(s == 3));
            chk("mem_req", 64'(bus.mem_req), 64'(s == 4));
            chk("reg_write_en", 64'(bus.reg_write_en), 64'(last_w && rw));
            chk("busy", 64'(bus.busy), 64'd1);
            chk("pc", bus.pc, m_pc);
            chk("cycle_count", 64'(bus.cycle_count), PERF ? 64'(m_cyc + 32'(k)) : 64'd0);
            chk("instr_count", 64'(bus.instr_count), PERF ? 64'(m_ins) : 64'd0);
            noise();
            if (last_e) begin
                bus.mem_read      = rd;
                bus.mem_write     = wr;
                bus.reg_write     = rw;
                bus.pc_src        = ps;
                bus.branch_target = tgt;
            end
            if (s == 4) begin
                bus.mem_ack = (mi == ack_dly - 1);
                mi++;
            end
            if (last_w) bus.run = cont;
        end
        m_pc  = ps ? tgt : m_pc + 64'd4;
        m_cyc = m_cyc + 32'(stg.size());
        m_ins = m_ins + 32'd1;
    endtask

    // Walk into EXECUTE of a fresh instruction, then hit reset there.
    task automatic abort_in_exec();
        for (int k = 0; k < FC + DC; k++) begin
            @(negedge clk);
            noise();
        end
        @(negedge clk);
        chk("abort_pre_stage", 64'(bus.stage), 64'd3);
        reset = 1'b1;
        #1;
        m_pc = RPC; m_cyc = 0; m_ins = 0;
        chk_quiet("rst_async");
        bus.run = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_hold_stage", 64'(bus.stage), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_release_stage", 64'(bus.stage), 64'd1);
        chk("rst_release_fetch", 64'(bus.fetch_en), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.run = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.reg_write = 1'b0;
        bus.mem_ack = 1'b0; bus.pc_src = 1'b0; bus.branch_target = '0;
        #12;
        chk_quiet("reset");
        @(negedge clk);
        reset = 1'b0;
        go_idle(1);

        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1, 1'b1);              // ALU
        do_instr(1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 3, 1'b1);              // load, ack after 3
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 64'h100, 1, 1'b1);            // branch
        chk("branch_pc", m_pc, 64'h100);
        do_instr(1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1'b1);
        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1, 1'b0);              // wraps to 0, stop
        go_idle(2);
        chk("wrap_pc", bus.pc, 64'd0);
        do_instr(1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 2, 1'b1);              // rd&wr: one access
        do_instr(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1, 1'b0);              // ack on entry cycle
        go_idle(0);

        for (int n = 0; n < 60; n++) begin
            bit rd, wr, rw, ps, cont;
            rd   = 1'($urandom);
            wr   = ($urandom_range(0, 3) == 0);
            rw   = 1'($urandom);
            ps   = ($urandom_range(0, 3) == 0);
            cont = ($urandom_range(0, 3) != 0);
            do_instr(rd, wr, rw, ps, {$urandom, $urandom}, $urandom_range(1, 5), cont);
            if (!cont) go_idle($urandom_range(0, 2));
        end

        abort_in_exec();
        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1, 1'b1);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1, 1'b1);
        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1, 1'b0);
        @(negedge clk);
        chk("three_alu_cycles", 64'(bus.cycle_count), PERF ? 64'd15 : 64'd0);
        chk("three_alu_instrs", 64'(bus.instr_count), PERF ? 64'd3 : 64'd0);
        chk("three_alu_pc", bus.pc, 64'd12);
        chk_quiet("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
